// File: rtl/datapath_pipe.sv
// Two-stage issue/execute datapath: register file, ALU, external load path and forwarding of the
// EX-stage result into issue, so dependent operations can issue back to back.
module datapath_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_DEPTH = 32,
    parameter int unsigned ADDR_W    = $clog2(REG_DEPTH),
    parameter bit          ZERO_REG  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [3:0]        alu_ctrl,
    input  logic              wr_en,
    input  logic              load_en,
    input  logic [XLEN-1:0]   load_data,
    output logic [XLEN-1:0]   result,
    output logic              zero_flag,
    output logic              out_valid
);

    localparam int unsigned ShW = $clog2(XLEN);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSll  = 4'b1000;
    localparam logic [3:0] OpSrl  = 4'b1001;
    localparam logic [3:0] OpSra  = 4'b1010;
    localparam logic [3:0] OpSltu = 4'b1011;
    localparam logic [3:0] OpNor  = 4'b1100;

    logic [XLEN-1:0]   rf_q [REG_DEPTH];

    logic              ex_valid_q;
    logic [3:0]        ex_ctrl_q;
    logic [ADDR_W-1:0] ex_rd_q;
    logic              ex_wr_q;
    logic              ex_load_q;
    logic [XLEN-1:0]   ex_load_data_q;
    logic [XLEN-1:0]   ex_a_q;
    logic [XLEN-1:0]   ex_b_q;

    logic [XLEN-1:0]   result_q;
    logic              zero_q;
    logic              out_valid_q;

    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   ex_value;
    logic              ex_wen;
    logic [ShW-1:0]    shamt;
    logic [ADDR_W-1:0] src_addr [2];
    logic [XLEN-1:0]   src_val [2];

    // A register is real storage only if it exists and is not the hardwired zero register.
    function automatic logic is_real_reg(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < REG_DEPTH) && !(ZERO_REG && (addr == '0));
    endfunction

    always_comb begin
        shamt = ex_b_q[ShW-1:0];
        case (ex_ctrl_q)
            OpAnd:   alu_out = ex_a_q & ex_b_q;
            OpOr:    alu_out = ex_a_q | ex_b_q;
            OpAdd:   alu_out = ex_a_q + ex_b_q;
            OpXor:   alu_out = ex_a_q ^ ex_b_q;
            OpSub:   alu_out = ex_a_q - ex_b_q;
            OpSlt:   alu_out = {{(XLEN-1){1'b0}}, $signed(ex_a_q) < $signed(ex_b_q)};
            OpSltu:  alu_out = {{(XLEN-1){1'b0}}, ex_a_q < ex_b_q};
            OpNor:   alu_out = ~(ex_a_q | ex_b_q);
            OpSll:   alu_out = ex_a_q << shamt;
            OpSrl:   alu_out = ex_a_q >> shamt;
            OpSra:   alu_out = $signed(ex_a_q) >>> shamt;
            default: alu_out = '0;
        endcase
    end

    assign ex_value = ex_load_q ? ex_load_data_q : alu_out;
    assign ex_wen   = ex_valid_q && ex_wr_q && is_real_reg(ex_rd_q);

    assign src_addr[0] = rs1_addr;
    assign src_addr[1] = rs2_addr;

    // The EX result is written at the same edge the dependent op issues, so bypass the file.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            src_val[i] = '0;
            if (is_real_reg(src_addr[i])) begin
                if (ex_wen && (ex_rd_q == src_addr[i])) begin
                    src_val[i] = ex_value;
                end else begin
                    src_val[i] = rf_q[src_addr[i]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_rd_q        <= '0;
            ex_wr_q        <= 1'b0;
            ex_load_q      <= 1'b0;
            ex_load_data_q <= '0;
            ex_a_q         <= '0;
            ex_b_q         <= '0;
            result_q       <= '0;
            zero_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            ex_valid_q <= in_valid;
            if (in_valid) begin
                ex_ctrl_q      <= alu_ctrl;
                ex_rd_q        <= rd_addr;
                ex_wr_q        <= wr_en;
                ex_load_q      <= load_en;
                ex_load_data_q <= load_data;
                ex_a_q         <= src_val[0];
                ex_b_q         <= src_val[1];
            end
            out_valid_q <= ex_valid_q;
            if (ex_valid_q) begin
                result_q <= ex_value;
                zero_q   <= (ex_value == '0);
            end
            if (ex_wen) begin
                rf_q[ex_rd_q] <= ex_value;
            end
        end
    end

    assign result    = result_q;
    assign zero_flag = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench for datapath_pipe: a sequential reference model predicts each result at issue,
// a negedge monitor pops and compares; a second XLEN=16/REG_DEPTH=8 instance covers wrap-around.
module tb_datapath_pipe;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  alu_ctrl;
    logic        wr_en, load_en;
    logic [31:0] load_data;
    logic [31:0] result;
    logic        zero_flag, out_valid;

    logic        in_valid16;
    logic [2:0]  rs1_16, rs2_16, rd_16;
    logic [3:0]  ctrl16;
    logic        wr16, ld16;
    logic [15:0] ldata16;
    logic [15:0] result16;
    logic        zero16, valid16;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    exp_t        sb[$];
    logic [31:0] mrf [32];
    logic [31:0] last_res;
    logic        last_zero;

    datapath_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rd_addr   (rd_addr),
        .alu_ctrl  (alu_ctrl),
        .wr_en     (wr_en),
        .load_en   (load_en),
        .load_data (load_data),
        .result    (result),
        .zero_flag (zero_flag),
        .out_valid (out_valid)
    );

    datapath_pipe #(.XLEN(16), .REG_DEPTH(8)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid16),
        .rs1_addr  (rs1_16),
        .rs2_addr  (rs2_16),
        .rd_addr   (rd_16),
        .alu_ctrl  (ctrl16),
        .wr_en     (wr16),
        .load_en   (ld16),
        .load_data (ldata16),
        .result    (result16),
        .zero_flag (zero16),
        .out_valid (valid16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        case (c)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h3:    return a ^ b;
            4'h6:    return a - b;
            4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hB:    return (a < b) ? 32'd1 : 32'd0;
            4'hC:    return ~(a | b);
            4'h8:    return a << b[4:0];
            4'h9:    return a >> b[4:0];
            4'hA:    return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Model applies each op in program order, which is what forwarding must make visible.
    task automatic op(input logic [3:0] c, input int rs1, input int rs2, input int rd,
                      input bit wr, input bit ld, input logic [31:0] ldata);
        logic [31:0] a, b, v;
        exp_t e;
        a = (rs1 == 0) ? 32'd0 : mrf[rs1];
        b = (rs2 == 0) ? 32'd0 : mrf[rs2];
        v = ld ? ldata : model_alu(c, a, b);
        e.due = cyc + 2;
        e.res = v;
        e.z   = (v == 32'd0);
        sb.push_back(e);
        if (wr && rd != 0) mrf[rd] = v;
        in_valid  = 1'b1;
        alu_ctrl  = c;
        rs1_addr  = 5'(rs1);
        rs2_addr  = 5'(rs2);
        rd_addr   = 5'(rd);
        wr_en     = wr;
        load_en   = ld;
        load_data = ldata;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int rd, input logic [31:0] v);
        op(4'h0, 0, 0, rd, 1'b1, 1'b1, v);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        repeat (n) @(posedge clk);
        #1;
        last_res  = 32'd0;
        last_zero = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic op16(input logic [3:0] c, input int rs1, input int rs2, input int rd,
                        input bit ld, input logic [15:0] v);
        in_valid16 = 1'b1;
        ctrl16     = c;
        rs1_16     = 3'(rs1);
        rs2_16     = 3'(rs2);
        rd_16      = 3'(rd);
        wr16       = 1'b1;
        ld16       = ld;
        ldata16    = v;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit   exp_v;
            exp_t e;
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            check("out_valid", 64'(out_valid), 64'(exp_v));
            if (exp_v) begin
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("zero_flag", 64'(zero_flag), 64'(e.z));
                last_res  = e.res;
                last_zero = e.z;
            end else begin
                check("result_hold", 64'(result), 64'(last_res));
                check("zero_hold", 64'(zero_flag), 64'(last_zero));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0; alu_ctrl = '0;
        wr_en = 1'b0; load_en = 1'b0; load_data = '0;
        in_valid16 = 1'b0; rs1_16 = '0; rs2_16 = '0; rd_16 = '0; ctrl16 = '0;
        wr16 = 1'b0; ld16 = 1'b0; ldata16 = '0;

        do_reset(2);
        check("reset_result", 64'(result), 64'd0);
        check("reset_zero", 64'(zero_flag), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_valid16", 64'(valid16), 64'd0);
        mon_en = 1'b1;

        op(4'h2, 1, 2, 0, 1'b0, 1'b0, 32'd0);          // ADD of cleared registers
        idle(2);

        load(4, 32'h12);
        load(20, 32'h2);
        load(5, 32'hA);
        op(4'h2, 5, 20, 9, 1'b1, 1'b0, 32'd0);         // 0xC
        op(4'h6, 5, 5, 9, 1'b1, 1'b0, 32'd0);          // 0

        load(1, 32'd7);
        op(4'h2, 1, 1, 2, 1'b1, 1'b0, 32'd0);          // 14, forwarded r1
        op(4'h2, 2, 1, 3, 1'b1, 1'b0, 32'd0);          // 21, forwarded r2 + file r1

        load(0, 32'h55);
        op(4'h1, 0, 0, 10, 1'b1, 1'b0, 32'd0);         // r0 never forwards
        op(4'h2, 0, 4, 11, 1'b1, 1'b0, 32'd0);         // 0x12

        load(6, 32'h8000_0000);
        load(7, 32'd35);
        op(4'hA, 6, 7, 12, 1'b1, 1'b0, 32'd0);         // SRA -> 0xF0000000
        op(4'h9, 6, 7, 13, 1'b1, 1'b0, 32'd0);         // SRL -> 0x10000000
        op(4'h7, 6, 7, 14, 1'b1, 1'b0, 32'd0);         // SLT -> 1
        op(4'hB, 6, 7, 15, 1'b1, 1'b0, 32'd0);         // SLTU -> 0
        op(4'h8, 7, 7, 16, 1'b1, 1'b0, 32'd0);         // SLL
        op(4'h3, 12, 13, 17, 1'b1, 1'b0, 32'd0);       // XOR
        op(4'hC, 4, 5, 18, 1'b1, 1'b0, 32'd0);         // NOR
        op(4'h0, 12, 3, 19, 1'b1, 1'b0, 32'd0);        // AND
        op(4'h6, 1, 2, 21, 1'b1, 1'b0, 32'd0);         // SUB wraps negative
        op(4'h4, 6, 7, 22, 1'b1, 1'b0, 32'd0);         // undefined code -> 0
        op(4'h2, 21, 12, 23, 1'b0, 1'b0, 32'd0);       // wr_en=0: r23 untouched
        op(4'h1, 23, 22, 24, 1'b1, 1'b0, 32'd0);
        idle(3);

        load(8, 32'h99);
        do_reset(1);                                   // discards the in-flight load
        idle(2);
        op(4'h2, 8, 8, 11, 1'b1, 1'b0, 32'd0);         // r8 reads 0
        idle(3);

        op16(4'h0, 0, 0, 1, 1'b1, 16'hFFFF);
        op16(4'h0, 0, 0, 2, 1'b1, 16'h0001);
        op16(4'h2, 1, 2, 3, 1'b0, 16'h0);
        in_valid16 = 1'b0;
        @(posedge clk);
        #1;
        check("x16_valid", 64'(valid16), 64'd1);
        check("x16_result", 64'(result16), 64'd0);
        check("x16_zero", 64'(zero16), 64'd1);
        @(posedge clk);
        #1;
        check("x16_valid_drop", 64'(valid16), 64'd0);
        check("x16_result_hold", 64'(result16), 64'd0);

        idle(3);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
